dmem_streamer: RTL and testbench
================================

# dmem_streamer

Read-side drain engine for the vector data memory. After the SIMD processor finishes writing results through the 256-bit port, this block reads a programmed range of 256-bit memory words. It serializes each word into sixteen 16-bit lanes on a valid/ready output stream for an external consumer such as a UART or debug link. It sits beside the processor and owns the memory's vector read port only while `busy` is high.

## Interface
- `ADDR_W`, 8: word-address width of the vector memory port.
- `LANE_W`, 16: width of one lane and of the output stream.
- `LANES`, 16: lanes per memory word; the word width is `LANE_W*LANES` = 256.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a drain; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; latched on an accepted `start`.
- `num_words`  in  ADDR_W+1  number of words to drain; latched on an accepted `start`.
- `mem_rd_en`  out  1  vector read strobe to the memory.
- `mem_addr`  out  ADDR_W  vector word address.
- `mem_q`  in  256  vector read data, valid one cycle after `mem_rd_en`.
- `out_data`  out  LANE_W  current lane.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the lane.
- `busy`  out  1  high from the accepted `start` until the end of DONE.
- `done`  out  1  one-cycle pulse when the drain completes.

## Operation
- FSM states are IDLE, REQ, WAIT, SHIFT and DONE.
- IDLE:
  - `start`=1 latches `cur_addr`←`base_addr` and `remaining`←`num_words`.
  - If `num_words`=0, go to DONE; otherwise go to REQ.
- REQ: drive `mem_rd_en`=1 with `mem_addr`=`cur_addr` for exactly one cycle, then go to WAIT.
- WAIT:
  - Capture `mem_q` into a 256-bit lane register and set `lane_idx`←0.
  - Increment `cur_addr` modulo 2^ADDR_W and decrement `remaining`, then go to SHIFT.
- SHIFT:
  - `out_valid`=1 and `out_data`=lane register bits [15:0]. Lane 0 is sent first, so the output order is bits [15:0] up to bits [255:240].
  - On `out_valid && out_ready`: shift the lane register right by LANE_W and increment `lane_idx`.
  - A handshake at `lane_idx`=LANES-1 goes to REQ if `remaining`≠0, else to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE. `busy` drops on the following cycle.
- `out_data` and `out_valid` must stay stable while `out_valid && !out_ready`.
- `start` is ignored while `busy`=1.
- `mem_rd_en` is never asserted outside REQ.

## Timing
- Reset values: state=IDLE, `mem_rd_en`=0, `mem_addr`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0, and all counters 0.
- Cycle t is the accepted `start`:
  - REQ at t+1.
  - WAIT at t+2 (capture `mem_q`).
  - First `out_valid` at t+3.
- With `out_ready` tied to 1:
  - Each word takes 2 + 16 = 18 cycles.
  - N words finish with `done` at t+1+18N.
  - There is no read prefetch; a 2-cycle bubble separates words.
- `out_ready` may toggle arbitrarily. Each low cycle stalls exactly one cycle, and no lane is lost or duplicated.
- `num_words` = 2^ADDR_W drains the whole memory. The address wraps to 0 after 2^ADDR_W−1.
- Reset asserted mid-drain returns to the reset values immediately, asynchronously. No `done` pulse is emitted.
- A `start` and `reset` in the same cycle: reset wins.

## Structure
- Shared package `dmem_stream_pkg` holds:
  - state enum `stream_state_t` (IDLE, REQ, WAIT, SHIFT, DONE);
  - localparams `LANE_W`, `LANES` and `VEC_W`=256.
- Sub-module `lane_serializer`:
  - 256-bit load/shift register plus a 4-bit lane counter;
  - inputs: `load`, `shift`;
  - outputs: `out_data`, `last_lane`.
- The top FSM owns addressing, the remaining-word count and the handshake.

## Test plan
- Single word at `base_addr`=0x05, holding `mem_q` lanes 0x0000..0x000F, `out_ready`=1:
  - exactly one read, at address 0x05;
  - output 0x0000, 0x0001, …, 0x000F on consecutive cycles;
  - `done` at t+19.
- `num_words`=0: no `mem_rd_en`, no `out_valid`; `done` at t+1, `busy` high for 2 cycles.
- Three words at `base_addr`=0xFE with ADDR_W=8:
  - reads at 0xFE, 0xFF, 0x00;
  - 48 lanes out in order;
  - `done` once.
- Random `out_ready` (50%) over 4 words:
  - scoreboard matches all 64 lanes;
  - `out_data` is held stable during every stall.
- `start` pulsed while busy: ignored, and the latched address and count are unchanged.
- Reset asserted in SHIFT at lane 7:
  - all outputs return to the reset values in the same cycle;
  - a fresh `start` then drains correctly from the new `base_addr`.

Source files
------------

// File: rtl/dmem_stream_pkg.sv
// rtl/dmem_stream_pkg.sv - shared types and constants for the vector memory drain engine
package dmem_stream_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 16;
    localparam int VEC_W  = LANE_W * LANES;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SHIFT,
        DONE
    } stream_state_t;

endpackage

// File: rtl/lane_serializer.sv
// rtl/lane_serializer.sv - 256-bit load/shift register that emits one lane at a time, lane 0 first
module lane_serializer #(
    parameter int LANE_W = 16,
    parameter int LANES  = 16,
    parameter int IDX_W  = $clog2(LANES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      shift,
    input  logic [LANE_W*LANES-1:0]   load_data,
    output logic [LANE_W-1:0]         out_data,
    output logic                      last_lane
);

    logic [LANE_W*LANES-1:0] shreg;
    logic [IDX_W-1:0]        lane_idx;

    // Load a fresh word, or drop the lane just accepted by shifting the next one into the low bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            lane_idx <= '0;
        end else if (load) begin
            shreg    <= load_data;
            lane_idx <= '0;
        end else if (shift) begin
            shreg    <= shreg >> LANE_W;
            lane_idx <= lane_idx + 1'b1;
        end
    end

    // Zeros fill in from the top, so a fully drained register presents 0 on out_data.
    assign out_data  = shreg[LANE_W-1:0];
    assign last_lane = (lane_idx == IDX_W'(LANES - 1));

endmodule

// File: rtl/dmem_streamer.sv
// rtl/dmem_streamer.sv - drains a range of 256-bit memory words as a stream of 16-bit lanes
module dmem_streamer #(
    parameter int ADDR_W = 8,
    parameter int LANE_W = 16,
    parameter int LANES  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          num_words,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [LANE_W*LANES-1:0]  mem_q,
    output logic [LANE_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    import dmem_stream_pkg::*;

    stream_state_t       state_q;
    stream_state_t       state_d;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W:0]     remaining;
    logic                busy_q;
    logic                accept;
    logic                ser_load;
    logic                ser_shift;
    logic                last_lane;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and serializer control; a new start is taken only once busy has fallen.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    accept  = 1'b1;
                    state_d = (num_words == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                ser_load = 1'b1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (out_ready) begin
                    ser_shift = 1'b1;
                    if (last_lane) begin
                        state_d = (remaining != '0) ? REQ : DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address and word count: latched on accept, advanced as each word's read data is captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
        end else if (accept) begin
            cur_addr  <= base_addr;
            remaining <= num_words;
        end else if (state_q == WAIT) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    // Busy rises with the accepted start and stays up through DONE plus the following IDLE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else if (accept) begin
            busy_q <= 1'b1;
        end else begin
            busy_q <= (state_q != IDLE);
        end
    end

    lane_serializer #(
        .LANE_W (LANE_W),
        .LANES  (LANES)
    ) u_lane_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .shift     (ser_shift),
        .load_data (mem_q),
        .out_data  (out_data),
        .last_lane (last_lane)
    );

    assign mem_rd_en = (state_q == REQ);
    assign mem_addr  = cur_addr;
    assign out_valid = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_streamer.sv
// tb/tb_dmem_streamer.sv - self-checking bench for dmem_streamer
module tb_dmem_streamer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [7:0]   base_addr;
    logic [8:0]   num_words;
    logic         mem_rd_en;
    logic [7:0]   mem_addr;
    logic [255:0] mem_q;
    logic [15:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [255:0] mem_words [256];
    logic [7:0]   addr_q [$];
    logic [15:0]  lane_q [$];

    logic         stall_prev = 1'b0;
    logic [15:0]  prev_data = '0;

    typedef struct {
        logic [7:0] base;
        logic [8:0] num;
        bit         rnd;
        int         exp_lat;
    } vec_t;

    vec_t vecs [4];

    dmem_streamer #(
        .ADDR_W (8),
        .LANE_W (16),
        .LANES  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_q     (mem_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_q <= mem_words[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every read address and every accepted lane is popped and compared.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd_en) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected read at %0h", mem_addr);
                end else begin
                    logic [7:0] ea;
                    ea = addr_q.pop_front();
                    if (mem_addr !== ea) begin
                        errors++;
                        $display("FAIL rd_addr: got %0h expected %0h", mem_addr, ea);
                    end
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (lane_q.size() == 0) begin
                    errors++;
                    $display("FAIL lane: unexpected lane %0h", out_data);
                end else begin
                    logic [15:0] el;
                    el = lane_q.pop_front();
                    if (out_data !== el) begin
                        errors++;
                        $display("FAIL lane: got %0h expected %0h", out_data, el);
                    end
                end
            end
            if (stall_prev) begin
                checks++;
                if (!out_valid || out_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid %0b data %0h expected valid 1 data %0h",
                             out_valid, out_data, prev_data);
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic do_start(input logic [7:0] b, input logic [8:0] n);
        for (int w = 0; w < int'(n); w++) begin
            logic [7:0] a;
            a = b + 8'(w);
            addr_q.push_back(a);
            for (int l = 0; l < 16; l++) lane_q.push_back(mem_words[a][l*16 +: 16]);
        end
        base_addr = b;
        num_words = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_drain(input logic [7:0] b, input logic [8:0] n, input bit rnd,
                             input int exp_lat, input int ghost_k);
        int  k;
        bit  got;
        done_cnt  = 0;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        do_start(b, n);
        k   = 1;
        got = 0;
        while (k < 3000) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
            k++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == ghost_k) begin
                base_addr = 8'h80;
                num_words = 9'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        if (exp_lat > 0) check("done_latency", k, exp_lat);
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_dropped", 32'(busy), 32'd0);
        check("done_count", done_cnt, 32'd1);
        check("addr_q_empty", addr_q.size(), 32'd0);
        check("lane_q_empty", lane_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        out_ready = 1'b1;
        mem_q     = '0;
        for (int a = 0; a < 256; a++)
            for (int l = 0; l < 16; l++) mem_words[a][l*16 +: 16] = 16'($urandom);
        for (int l = 0; l < 16; l++) mem_words[5][l*16 +: 16] = 16'(l);

        vecs[0] = '{base: 8'h05, num: 9'd1, rnd: 1'b0, exp_lat: 19};
        vecs[1] = '{base: 8'h40, num: 9'd0, rnd: 1'b0, exp_lat: 1};
        vecs[2] = '{base: 8'hFE, num: 9'd3, rnd: 1'b0, exp_lat: 55};
        vecs[3] = '{base: 8'h60, num: 9'd4, rnd: 1'b1, exp_lat: 0};

        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            run_drain(vecs[i].base, vecs[i].num, vecs[i].rnd, vecs[i].exp_lat, 0);

        // start pulsed mid-drain must not disturb the two-word drain from 0x10
        run_drain(8'h10, 9'd2, 1'b0, 37, 5);

        // reset while lane 7 of the first word is on the output
        done_cnt  = 0;
        out_ready = 1'b1;
        do_start(8'h20, 9'd2);
        repeat (9) @(posedge clk);
        #2;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        check("pre_reset_lane7", 32'(out_data), 32'(mem_words[8'h20][7*16 +: 16]));
        reset = 1'b1;
        #1;
        check("mid_rst_outputs", {busy, done, out_valid, mem_rd_en, mem_addr, out_data},
              32'd0);
        addr_q.delete();
        lane_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_rst", done_cnt, 32'd0);
        run_drain(8'h33, 9'd1, 1'b0, 19, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
